// File: rtl/ed25519_pkg.sv
// rtl/ed25519_pkg.sv - shared ed25519 field constants, point_encode FSM states, reduction helper
package ed25519_pkg;

   localparam int ED_B = 256;

   // Field prime q = 2^255 - 19
   localparam logic [ED_B-1:0] ED_Q =
      256'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffed;

   // Fermat inversion exponent q - 2 = 2^255 - 21 (bits 2 and 4 clear)
   localparam logic [ED_B-1:0] ED_Q_M2 =
      256'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffeb;

   typedef enum logic [2:0] {
      PE_IDLE,
      PE_LOAD,
      PE_INV_SQ,
      PE_INV_MUL,
      PE_MUL_X,
      PE_MUL_Y,
      PE_FINISH
   } pe_state_t;

   // One conditional subtract of q
   function automatic logic [ED_B-1:0] ed_csub(input logic [ED_B-1:0] v);
      return (v >= ED_Q) ? v - ED_Q : v;
   endfunction

endpackage

// File: rtl/mod_mul.sv
// rtl/mod_mul.sv - bit-serial interleaved modular multiplier mod q, fixed 258-cycle latency
module mod_mul
   import ed25519_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [ED_B-1:0] a,
   input  logic [ED_B-1:0] b,
   output logic            done,
   output logic [ED_B-1:0] p
);

   localparam logic [ED_B+1:0] Q_W = {2'b00, ED_Q};

   logic [ED_B-1:0] a_q, a_d;
   logic [ED_B-1:0] b_q, b_d;
   logic [ED_B-1:0] acc_q, acc_d;
   logic [ED_B-1:0] p_q, p_d;
   logic [8:0]      cnt_q, cnt_d;
   logic            run_q, run_d;
   logic            done_q, done_d;
   logic [ED_B+1:0] t, t1, t2;
   logic            unused_hi;

   // Load, then one cycle finishing the reduction of b, then 256 MSB-first shift-add steps
   always_comb begin
      a_d       = a_q;
      b_d       = b_q;
      acc_d     = acc_q;
      p_d       = p_q;
      cnt_d     = cnt_q;
      run_d     = run_q;
      done_d    = 1'b0;
      t         = {1'b0, acc_q, 1'b0} + (a_q[ED_B-1] ? {2'b00, b_q} : '0);
      t1        = (t  >= Q_W) ? t  - Q_W : t;
      t2        = (t1 >= Q_W) ? t1 - Q_W : t1;
      unused_hi = ^t2[ED_B+1:ED_B];
      if (run_q) begin
         if (cnt_q == 9'd0) begin
            // b < 2^256 < 3q, so a second subtract leaves it fully reduced
            b_d   = ed_csub(b_q);
            cnt_d = 9'd1;
         end else begin
            acc_d = t2[ED_B-1:0];
            a_d   = a_q << 1;
            cnt_d = cnt_q + 9'd1;
            if (cnt_q == 9'd256) begin
               run_d  = 1'b0;
               done_d = 1'b1;
               p_d    = t2[ED_B-1:0];
            end
         end
      end else if (start) begin
         a_d   = a;
         b_d   = ed_csub(b);
         acc_d = '0;
         cnt_d = 9'd0;
         run_d = 1'b1;
      end
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q    <= '0;
         b_q    <= '0;
         acc_q  <= '0;
         p_q    <= '0;
         cnt_q  <= '0;
         run_q  <= 1'b0;
         done_q <= 1'b0;
      end else begin
         a_q    <= a_d;
         b_q    <= b_d;
         acc_q  <= acc_d;
         p_q    <= p_d;
         cnt_q  <= cnt_d;
         run_q  <= run_d;
         done_q <= done_d;
      end
   end

   assign done = done_q;
   assign p    = p_q;

endmodule

// File: rtl/point_encode.sv
// rtl/point_encode.sv - extended-to-affine conversion and compressed ed25519 point encoding
module point_encode
   import ed25519_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [ED_B-1:0] x,
   input  logic [ED_B-1:0] y,
   input  logic [ED_B-1:0] z,
   output logic            busy,
   output logic            done,
   output logic            err,
   output logic [ED_B-1:0] x_aff,
   output logic [ED_B-1:0] y_aff,
   output logic [ED_B-1:0] enc
);

   pe_state_t       state_q, state_d;
   logic [7:0]      idx_q, idx_d;
   logic [ED_B-1:0] acc_q, acc_d;
   logic [ED_B-1:0] zr_q, zr_d;
   logic [ED_B-1:0] xr_q, xr_d;
   logic [ED_B-1:0] yr_q, yr_d;
   logic            issued_q, issued_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            err_q, err_d;
   logic [ED_B-1:0] x_aff_q, x_aff_d;
   logic [ED_B-1:0] y_aff_q, y_aff_d;
   logic [ED_B-1:0] enc_q, enc_d;

   logic            mm_start, mm_done, step_bit;
   logic [ED_B-1:0] mm_a, mm_b, mm_p;

   mod_mul u_mod_mul (
      .clk   (clk),
      .rst_n (rst_n),
      .start (mm_start),
      .a     (mm_a),
      .b     (mm_b),
      .done  (mm_done),
      .p     (mm_p)
   );

   // Sequencer: each multiply state pulses mm start once, then waits for its done
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      acc_d    = acc_q;
      zr_d     = zr_q;
      xr_d     = xr_q;
      yr_d     = yr_q;
      issued_d = issued_q;
      busy_d   = busy_q;
      done_d   = done_q;
      err_d    = err_q;
      x_aff_d  = x_aff_q;
      y_aff_d  = y_aff_q;
      enc_d    = enc_q;
      mm_start = 1'b0;
      mm_a     = acc_q;
      mm_b     = acc_q;
      step_bit = 1'b0;

      if ((state_q == PE_INV_SQ) || (state_q == PE_INV_MUL) ||
          (state_q == PE_MUL_X) || (state_q == PE_MUL_Y)) begin
         if (!issued_q) begin
            mm_start = 1'b1;
            issued_d = 1'b1;
         end
      end

      case (state_q)
         PE_IDLE: begin
            if (start) begin
               xr_d    = x;
               yr_d    = y;
               zr_d    = z;
               busy_d  = 1'b1;
               done_d  = 1'b0;
               state_d = PE_LOAD;
            end
         end
         PE_LOAD: begin
            // Bit 254 of the exponent is consumed by starting acc at z
            zr_d    = ed_csub(zr_q);
            acc_d   = ed_csub(zr_q);
            idx_d   = 8'd253;
            state_d = PE_INV_SQ;
         end
         PE_INV_SQ: begin
            if (issued_q && mm_done) begin
               acc_d    = mm_p;
               issued_d = 1'b0;
               if (ED_Q_M2[idx_q]) state_d = PE_INV_MUL;
               else                step_bit = 1'b1;
            end
         end
         PE_INV_MUL: begin
            mm_a = zr_q;
            if (issued_q && mm_done) begin
               acc_d    = mm_p;
               issued_d = 1'b0;
               step_bit = 1'b1;
            end
         end
         PE_MUL_X: begin
            mm_a = xr_q;
            if (issued_q && mm_done) begin
               xr_d     = mm_p;
               issued_d = 1'b0;
               state_d  = PE_MUL_Y;
            end
         end
         PE_MUL_Y: begin
            mm_a = yr_q;
            if (issued_q && mm_done) begin
               yr_d     = mm_p;
               issued_d = 1'b0;
               state_d  = PE_FINISH;
            end
         end
         PE_FINISH: begin
            // Results are published together so outputs never show a half-updated point
            x_aff_d = xr_q;
            y_aff_d = yr_q;
            enc_d   = {xr_q[0], yr_q[ED_B-2:0]};
            err_d   = (acc_q == '0);
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = PE_IDLE;
         end
         default: state_d = PE_IDLE;
      endcase

      if (step_bit) begin
         if (idx_q == 8'd0) begin
            state_d = PE_MUL_X;
         end else begin
            idx_d   = idx_q - 8'd1;
            state_d = PE_INV_SQ;
         end
      end
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= PE_IDLE;
         idx_q    <= '0;
         acc_q    <= '0;
         zr_q     <= '0;
         xr_q     <= '0;
         yr_q     <= '0;
         issued_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         x_aff_q  <= '0;
         y_aff_q  <= '0;
         enc_q    <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         acc_q    <= acc_d;
         zr_q     <= zr_d;
         xr_q     <= xr_d;
         yr_q     <= yr_d;
         issued_q <= issued_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         err_q    <= err_d;
         x_aff_q  <= x_aff_d;
         y_aff_q  <= y_aff_d;
         enc_q    <= enc_d;
      end
   end

   assign busy  = busy_q;
   assign done  = done_q;
   assign err   = err_q;
   assign x_aff = x_aff_q;
   assign y_aff = y_aff_q;
   assign enc   = enc_q;

endmodule

// File: tb/tb_point_encode.sv
// tb/tb_point_encode.sv - self-checking bench for point_encode
module tb_point_encode;
   import ed25519_pkg::*;

   localparam int LAT = 131575;

   localparam logic [255:0] BX  = 256'h216936d3cd6e53fec0a4e231fdd6dc5c692cc7609525a7b2c9562d608f25d51a;
   localparam logic [255:0] BY  = 256'h6666666666666666666666666666666666666666666666666666666666666658;
   localparam logic [255:0] ENC_B  = 256'h6666666666666666666666666666666666666666666666666666666666666658;
   localparam logic [255:0] ENC_NB = 256'he666666666666666666666666666666666666666666666666666666666666658;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [255:0] x = '0, y = '0, z = '0;
   logic         busy, done, err;
   logic [255:0] x_aff, y_aff, enc;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   always #5 clk = ~clk;

   point_encode dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .x     (x),
      .y     (y),
      .z     (z),
      .busy  (busy),
      .done  (done),
      .err   (err),
      .x_aff (x_aff),
      .y_aff (y_aff),
      .enc   (enc)
   );

   task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
         if (n_fail > 50) begin
            $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
            $finish;
         end
      end
   endtask

   // Reference arithmetic: plain wide multiply and modulo, inverse by exponentiation
   function automatic logic [255:0] mulmod(input logic [255:0] a, input logic [255:0] b);
      logic [511:0] pr;
      pr = {256'b0, a} * {256'b0, b};
      pr = pr % {256'b0, ED_Q};
      return pr[255:0];
   endfunction

   function automatic logic [255:0] powmod(input logic [255:0] base, input logic [255:0] e);
      logic [255:0] r, bb;
      r  = 256'd1;
      bb = base % ED_Q;
      for (int i = 255; i >= 0; i--) begin
         r = mulmod(r, r);
         if (e[i]) r = mulmod(r, bb);
      end
      return r;
   endfunction

   // Model: accepted request produces its results exactly LAT cycles after the accept cycle
   logic         m_run = 1'b0, m_busy = 1'b0, m_done = 1'b0, m_err = 1'b0;
   logic [255:0] m_x = '0, m_y = '0, m_enc = '0;
   logic         p_err;
   logic [255:0] p_x, p_y, p_inv;
   int           m_cnt = 0;

   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_run = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0;
            m_x = '0; m_y = '0; m_enc = '0; m_cnt = 0;
         end else if (m_run) begin
            m_cnt++;
            if (m_cnt == LAT) begin
               m_run = 1'b0; m_busy = 1'b0; m_done = 1'b1;
               m_x = p_x; m_y = p_y; m_err = p_err;
               m_enc = {p_x[0], p_y[254:0]};
            end
         end else if (start) begin
            p_inv = powmod(z, ED_Q - 256'd2);
            p_x   = mulmod(x, p_inv);
            p_y   = mulmod(y, p_inv);
            p_err = ((z % ED_Q) == 256'd0);
            m_run = 1'b1; m_busy = 1'b1; m_done = 1'b0; m_cnt = 1;
         end
      end
   end

   // Cycle-by-cycle comparison against the model
   initial begin
      forever begin
         @(negedge clk);
         if (chk_en) begin
            chk("cyc_busy",  256'(busy), 256'(m_busy));
            chk("cyc_done",  256'(done), 256'(m_done));
            chk("cyc_err",   256'(err),  256'(m_err));
            chk("cyc_x_aff", x_aff, m_x);
            chk("cyc_y_aff", y_aff, m_y);
            chk("cyc_enc",   enc,   m_enc);
         end
      end
   end

   task automatic do_start(input bit at_neg, input logic [255:0] xi, input logic [255:0] yi,
                           input logic [255:0] zi);
      if (at_neg) @(negedge clk);
      x = xi; y = yi; z = zi;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // Counts cycles from the accept cycle until done is seen; optionally pokes a start mid-run
   task automatic wait_done(input int poke_at, output int lat, output logic fd, output logic [255:0] fe);
      lat = 0;
      fd  = 1'b0;
      fe  = '0;
      while (lat < LAT + 1000) begin
         lat++;
         @(negedge clk);
         if (lat == 1) begin
            fd = done;
            fe = enc;
         end
         if (lat == poke_at) begin
            x = 256'd3; z = 256'd0; start = 1'b1;
         end else begin
            start = 1'b0;
         end
         if (done) return;
         @(posedge clk);
      end
   endtask

   int           lat;
   logic         fd;
   logic [255:0] fe;

   initial begin
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      chk_en = 1'b1;
      @(negedge clk);
      chk("rst_busy", 256'(busy), 256'd0);
      chk("rst_done", 256'(done), 256'd0);
      chk("rst_enc",  enc, 256'd0);
      rst_n = 1'b1;

      // Identity point
      do_start(1'b1, 256'd0, 256'd1, 256'd1);
      wait_done(0, lat, fd, fe);
      chk("s1_latency", 256'(lat), 256'(LAT));
      chk("s1_x_aff", x_aff, 256'd0);
      chk("s1_y_aff", y_aff, 256'd1);
      chk("s1_enc",   enc,   256'd1);
      chk("s1_err",   256'(err), 256'd0);

      // Abort a run with reset at cycle 1000
      do_start(1'b1, BX, BY, 256'd1);
      repeat (999) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("abort_busy",  256'(busy), 256'd0);
      chk("abort_done",  256'(done), 256'd0);
      chk("abort_y_aff", y_aff, 256'd0);
      chk("abort_enc",   enc,   256'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Base point, z = 1
      do_start(1'b1, BX, BY, 256'd1);
      wait_done(0, lat, fd, fe);
      chk("s2_latency", 256'(lat), 256'(LAT));
      chk("s2_x_aff", x_aff, BX);
      chk("s2_enc",   enc,   ENC_B);
      chk("s2_err",   256'(err), 256'd0);

      // Base point scaled by 2, with an ignored start in the middle of the run
      do_start(1'b1, BX << 1, BY << 1, 256'd2);
      wait_done(500, lat, fd, fe);
      chk("s3_latency", 256'(lat), 256'(LAT));
      chk("s3_x_aff", x_aff, BX);
      chk("s3_y_aff", y_aff, BY);
      chk("s3_enc",   enc,   ENC_B);

      // Negated base point
      do_start(1'b1, ED_Q - BX, BY, 256'd1);
      wait_done(0, lat, fd, fe);
      chk("s4_enc",   enc,   ENC_NB);
      chk("s4_x_aff", x_aff, ED_Q - BX);

      // Back-to-back start on the done cycle, z = 0
      do_start(1'b0, 256'd5, 256'd7, 256'd0);
      wait_done(0, lat, fd, fe);
      chk("b2b_done_drop", 256'(fd), 256'd0);
      chk("b2b_enc_hold",  fe, ENC_NB);
      chk("s5a_latency", 256'(lat), 256'(LAT));
      chk("s5a_err",   256'(err), 256'd1);
      chk("s5a_enc",   enc,   256'd0);
      chk("s5a_x_aff", x_aff, 256'd0);
      chk("s5a_y_aff", y_aff, 256'd0);

      // z = q
      do_start(1'b1, 256'd5, 256'd7, ED_Q);
      wait_done(0, lat, fd, fe);
      chk("s5b_latency", 256'(lat), 256'(LAT));
      chk("s5b_err", 256'(err), 256'd1);
      chk("s5b_enc", enc, 256'd0);

      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
